// File: rtl/seg7_pkg.sv
// Shared glyph codes and dark-display constants for the 7-segment display blocks.
package seg7_pkg;
    localparam logic [3:0] GLYPH_R    = 4'hA;
    localparam logic [3:0] GLYPH_G    = 4'hB;
    localparam logic [3:0] GLYPH_D    = 4'hC;
    localparam logic [3:0] GLYPH_E    = 4'hD;
    localparam logic [3:0] GLYPH_O    = 4'hE;
    localparam logic [3:0] GLYPH_DASH = 4'hF;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;
endpackage

// File: rtl/seg7_glyph_decode.sv
// Glyph code to active-low {g,f,e,d,c,b,a}; purely combinational, no backpressure.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            4'h0:       o_seg = 7'h40;
            4'h1:       o_seg = 7'h79;
            4'h2:       o_seg = 7'h24;
            4'h3:       o_seg = 7'h30;
            4'h4:       o_seg = 7'h19;
            4'h5:       o_seg = 7'h12;
            4'h6:       o_seg = 7'h02;
            4'h7:       o_seg = 7'h78;
            4'h8:       o_seg = 7'h00;
            4'h9:       o_seg = 7'h10;
            GLYPH_R:    o_seg = 7'h2F;
            GLYPH_G:    o_seg = 7'h42;
            GLYPH_D:    o_seg = 7'h21;
            GLYPH_E:    o_seg = 7'h06;
            GLYPH_O:    o_seg = 7'h23;
            GLYPH_DASH: o_seg = 7'h3F;
            default:    o_seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit scan driver: snapshots A..D/blank once per frame, an/seg registered one cycle after each digit tick.
// Optional SEG_BLINK_EN builds the whole-display blink counter; without it the blink input is ignored.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int CNT_W        = 17,
    parameter int BLINK_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] blank,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_idx;
    logic [3:0][3:0]   r_snap_code;
    logic [3:0]        r_snap_blank;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_frame_tick;

    logic              w_tick;
    logic              w_wrap;
    logic [1:0]        w_idx_nxt;
    logic [3:0][3:0]   w_code_nxt;
    logic [3:0]        w_blank_nxt;
    logic [3:0]        w_code_sel;
    logic              w_dark;
    logic [3:0]        w_an_sel;
    logic [6:0]        w_seg_dec;
    logic              w_lit;

    assign w_tick      = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_wrap      = w_tick && (r_idx == 2'd3);
    assign w_idx_nxt   = r_idx + 2'd1;
    // On wrap the new digit must come from the fresh snapshot, not the stale one.
    assign w_code_nxt  = w_wrap ? {D, C, B, A} : r_snap_code;
    assign w_blank_nxt = w_wrap ? blank : r_snap_blank;
    assign w_code_sel  = w_code_nxt[w_idx_nxt];
    assign w_dark      = w_blank_nxt[2'd3 - w_idx_nxt];
    assign w_an_sel    = ~(4'b0001 << (2'd3 - w_idx_nxt));

    seg7_glyph_decode u_decode (
        .i_code (w_code_sel),
        .o_seg  (w_seg_dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_snap_code  <= '0;
            r_snap_blank <= 4'b1111;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_frame_tick <= w_wrap;
            if (w_tick) begin
                r_idx        <= w_idx_nxt;
                r_snap_code  <= w_code_nxt;
                r_snap_blank <= w_blank_nxt;
                r_an         <= w_dark ? AN_OFF  : w_an_sel;
                r_seg        <= w_dark ? SEG_OFF : w_seg_dec;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BCW-1:0] r_blink_cnt;
    logic           r_blink_on;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!blink) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_wrap) begin
            if (r_blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BCW'(1);
            end
        end
    end

    assign w_lit = r_blink_on;
`else
    logic w_unused_blink;
    assign w_unused_blink = blink & (BLINK_FRAMES > 0);
    assign w_lit          = 1'b1;
`endif

    assign an         = w_lit ? r_an  : AN_OFF;
    assign seg        = w_lit ? r_seg : SEG_OFF;
    assign dp         = 1'b1;
    assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 (16-cycle frames).
module tb_seg7_scan_driver;
    logic       clk;
    logic       reset;
    logic [3:0] A, B, C, D, blank;
    logic       blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int n_chk  = 0;
    int n_pass = 0;

    logic [6:0] exp_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h2F, 7'h42, 7'h21, 7'h06, 7'h23, 7'h3F};

    seg7_scan_driver #(
        .REFRESH_DIV  (4),
        .CNT_W        (3),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .blank      (blank),
        .blink      (blink),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    // n rising edges, then sample 1 ns later
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        A = 4'h5; B = 4'h6; C = 4'h7; D = 4'h8; blank = 4'b0000; blink = 1'b1;

        for (int i = 0; i < 5; i++) begin
            adv(1);
            check("rst_an", {28'd0, an}, 32'hF);
            check("rst_seg", {25'd0, seg}, 32'h7F);
            check("rst_dp", {31'd0, dp}, 32'd1);
            check("rst_ft", {31'd0, frame_tick}, 32'd0);
        end

        A = 4'h0; B = 4'hA; C = 4'hC; D = 4'h4; blank = 4'b1000; blink = 1'b0;
        reset = 1'b1;

        for (int i = 1; i < 16; i++) begin
            adv(1);
            check("dark_an", {28'd0, an}, 32'hF);
            check("dark_ft", {31'd0, frame_tick}, 32'd0);
        end
        adv(1);
        check("f1_ft", {31'd0, frame_tick}, 32'd1);
        check("f1_an_blankA", {28'd0, an}, 32'hF);
        check("f1_seg_blankA", {25'd0, seg}, 32'h7F);
        adv(1);
        check("f1_ft_drop", {31'd0, frame_tick}, 32'd0);
        adv(3);
        check("dB_an", {28'd0, an}, 32'hB);
        check("dB_seg", {25'd0, seg}, 32'h2F);
        C = 4'hB;
        adv(4);
        check("dC_an", {28'd0, an}, 32'hD);
        check("dC_seg_old", {25'd0, seg}, 32'h21);
        adv(4);
        check("dD_an", {28'd0, an}, 32'hE);
        check("dD_seg", {25'd0, seg}, 32'h19);
        adv(4);
        check("f2_ft", {31'd0, frame_tick}, 32'd1);
        adv(8);
        check("dC_an2", {28'd0, an}, 32'hD);
        check("dC_seg_new", {25'd0, seg}, 32'h42);

        blank = 4'b1111;
        adv(8);
        check("allblank_ft", {31'd0, frame_tick}, 32'd1);
        check("allblank_an0", {28'd0, an}, 32'hF);
        check("allblank_seg0", {25'd0, seg}, 32'h7F);
        for (int s = 1; s < 4; s++) begin
            adv(4);
            check("allblank_an", {28'd0, an}, 32'hF);
            check("allblank_seg", {25'd0, seg}, 32'h7F);
            check("allblank_ft0", {31'd0, frame_tick}, 32'd0);
        end
        adv(4);
        check("allblank_ft_next", {31'd0, frame_tick}, 32'd1);

        blank = 4'b0000;
        for (int c = 0; c < 16; c++) begin
            A = 4'(c); B = 4'(c); C = 4'(c); D = 4'(c);
            adv(16);
            check("dec_ft", {31'd0, frame_tick}, 32'd1);
            check("dec_an", {28'd0, an}, 32'h7);
            check("dec_seg", {25'd0, seg}, {25'd0, exp_tab[c]});
        end

        adv(8);
        check("mid_an", {28'd0, an}, 32'hD);
        #3;
        reset = 1'b0;
        #1;
        check("async_an", {28'd0, an}, 32'hF);
        check("async_seg", {25'd0, seg}, 32'h7F);
        check("async_ft", {31'd0, frame_tick}, 32'd0);
        adv(2);
        A = 4'h8; blank = 4'b0000;
        reset = 1'b1;
        for (int i = 1; i < 16; i++) begin
            adv(1);
            check("rerst_ft", {31'd0, frame_tick}, 32'd0);
            check("rerst_an", {28'd0, an}, 32'hF);
        end
        adv(1);
        check("rerst_ft16", {31'd0, frame_tick}, 32'd1);
        check("rerst_an16", {28'd0, an}, 32'h7);
        check("rerst_seg16", {25'd0, seg}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
